matvec_sequencer: RTL

MATVEC_SEQUENCER -- requirements
Module: matvec_sequencer

---
 rtl/matvec_sequencer_pkg.sv | 25 ++
 rtl/matvec_sequencer_mac_unit.sv | 38 +++
 rtl/matvec_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/matvec_sequencer_pkg.sv
// Shared types and default sizing for the matrix-vector sequencer.
// The accumulator width derivation covers COLS full-width products.
package matvec_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ROWS       = 8;
  localparam int DEF_COLS       = 8;

  // At least product width plus log2(COLS) of growth, never below 3 bytes of data width.
  function automatic int acc_width_for(input int data_width, input int cols);
    int need;
    need = 2 * data_width + $clog2(cols);
    return (need > 3 * data_width) ? need : 3 * data_width;
  endfunction

  localparam int DEF_ACC_WIDTH = acc_width_for(DEF_DATA_WIDTH, DEF_COLS);

endpackage

// File: rtl/matvec_sequencer_mac_unit.sv
// One multiply-accumulate lane: unsigned product, zero-extended, wraps modulo 2^ACC_WIDTH.
// clr has priority over en so a new product always starts from zero.
module mac_unit
  import matvec_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0]  acc
);

  logic [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]    acc_r;

  assign prod = a * b;

  // accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + ACC_WIDTH'(prod);
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/matvec_sequencer.sv
// Sequences FIFO reads for C = A*B on a diagonally skewed row of MAC lanes.
// B flows down a register chain so row i pairs A[i][k] with B[k] i cycles later.
module matvec_sequencer
  import matvec_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]      a_q,
  input  logic [ROWS-1:0]                      a_rdempty,
  output logic [ROWS-1:0]                      a_rdreq,
  input  logic [DATA_WIDTH-1:0]                b_q,
  input  logic                                 b_rdempty,
  output logic                                 b_rdreq,
  output logic [ROWS-1:0][ACC_WIDTH-1:0]       c_out,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int RUN_LAST = ROWS + COLS - 1;
  localparam int CNT_W    = $clog2(ROWS + COLS);

  state_t                            state_r;
  state_t                            state_nxt;
  logic [CNT_W-1:0]                  cnt_r;
  logic [CNT_W-1:0]                  run_cycle;
  logic                              all_ready;
  logic                              accept;
  logic                              go;
  logic                              run_active;
  logic                              rd_fault;
  logic                              busy_r;
  logic                              done_r;
  logic                              err_r;
  logic [ROWS-1:0]                   vld_r;
  logic [ROWS-1:1][DATA_WIDTH-1:0]   b_chain_r;
  logic [ROWS-1:0][DATA_WIDTH-1:0]   b_tap;
  logic [ROWS-1:0][ACC_WIDTH-1:0]    acc;

  assign all_ready = ~b_rdempty & ~(|a_rdempty);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // next state; the WAIT cycle that sees all FIFOs ready is already RUN cycle 0
  always_comb begin
    state_nxt = state_r;
    accept    = 1'b0;
    go        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (all_ready) begin
          go        = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_W'(RUN_LAST)) begin
          state_nxt = ST_FINISH;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_FINISH: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign run_active = go | (state_r == ST_RUN);
  assign run_cycle  = go ? '0 : cnt_r;

  // read request windows: B on cycles 0..COLS-1, row i skewed by i
  always_comb begin
    a_rdreq = '0;
    b_rdreq = run_active & (run_cycle < CNT_W'(COLS));
    for (int i = 0; i < ROWS; i++) begin
      a_rdreq[i] = run_active
                 & (run_cycle >= CNT_W'(i))
                 & (run_cycle <  CNT_W'(i + COLS));
    end
  end

  assign rd_fault = (b_rdreq & b_rdempty) | (|(a_rdreq & a_rdempty));

  // RUN cycle counter; RUN state is entered at cycle 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (go) begin
      cnt_r <= CNT_W'(1);
    end else if (state_r == ST_RUN) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      busy_r <= (state_nxt != ST_IDLE);
      done_r <= (state_nxt == ST_FINISH);
      if (accept) begin
        err_r <= 1'b0;
      end else if (rd_fault) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign err  = err_r;

  // valid and B delay chains; a read issued on cycle n yields data on cycle n+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r     <= '0;
      b_chain_r <= '0;
    end else begin
      vld_r[0] <= b_rdreq;
      for (int j = 1; j < ROWS; j++) begin
        vld_r[j] <= vld_r[j-1];
      end
      b_chain_r[1] <= b_q;
      for (int j = 2; j < ROWS; j++) begin
        b_chain_r[j] <= b_chain_r[j-1];
      end
    end
  end

  // B value aligned to each row's A data
  always_comb begin
    b_tap    = '0;
    b_tap[0] = b_q;
    for (int j = 1; j < ROWS; j++) begin
      b_tap[j] = b_chain_r[j];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_mac
    mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (vld_r[i]),
      .a     (a_q[i]),
      .b     (b_tap[i]),
      .acc   (acc[i])
    );
  end

  assign c_out = acc;

endmodule
